pla_slice_id_gen: RTL and testbench
===================================

PLA_SLICE_ID_GEN -- requirements
Module: pla_slice_id_gen

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 1, meaning idle cycles forced between slices (legal 1..15).
REQ-002 The block SHALL have parameter ID_INIT, default 15'h0000, meaning the first slice ID issued after reset or ID clear.
REQ-003 The block SHALL have port I_pla_312m5_clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port I_pla_rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port I_pla_data, input, 32 bits: the ingress payload word.
REQ-006 The block SHALL have port I_pla_data_vld, input, 1 bit: the ingress word is valid.
REQ-007 The block SHALL have port I_pla_eop, input, 1 bit: the ingress word is the last word of a packet.
REQ-008 The block SHALL have port O_pla_data_rdy, output, 1 bit: the block accepts the ingress word this cycle.
REQ-009 The block SHALL have port I_slice_len, input, 8 bits: payload words per slice.
REQ-010 The block SHALL have port I_id_clear, input, 1 bit: reload the next ID to ID_INIT.
REQ-011 The block SHALL have port I_cnt_clear, input, 1 bit: clear the statistics counter.
REQ-012 The block SHALL have port O_pla_slice_id, output, 15 bits: the ID of the current slice.
REQ-013 The block SHALL have port O_pla_slice_payload, output, 32 bits: the slice word.
REQ-014 The block SHALL have port O_pla_slice_en, output, 1 bit: the slice word is valid.
REQ-015 The block SHALL have port O_slice_cnt, output, 16 bits: the number of slices emitted.

Function
REQ-016 An ingress transfer SHALL occur only in a cycle where I_pla_data_vld=1 and O_pla_data_rdy=1.
REQ-017 Each transferred word SHALL appear on O_pla_slice_payload with O_pla_slice_en=1 exactly 1 cycle later, since all outputs are registered.
REQ-018 The FSM SHALL have three states, IDLE, SLICE and GAP, with the following transitions:
- IDLE->SLICE on the first transfer.
- SLICE->GAP when the transfer count reaches the effective length, or on a transfer with I_pla_eop=1.
- GAP->IDLE after GAP_CYCLES cycles.
REQ-019 O_pla_data_rdy SHALL be 1 in IDLE and SLICE, and SHALL be 0 in GAP.
REQ-020 O_pla_slice_en SHALL be 0 for at least GAP_CYCLES cycles between slices, so that every slice starts on a rising edge of O_pla_slice_en.
REQ-021 A vld gap inside SLICE SHALL drop O_pla_slice_en without ending the slice.
- Downstream consumers detect slices by the rising edge of O_pla_slice_en.
- Senders SHALL keep vld continuous within a slice.
REQ-022 I_slice_len SHALL be sampled at slice start and held for the whole slice; the value 0 SHALL be treated as 1.
REQ-023 O_pla_slice_id SHALL be constant for every word of a slice.
REQ-024 The ID SHALL increment by 1 per slice, modulo 2^15, with 15'h7FFF wrapping to 15'h0000.
REQ-025 The first slice after reset SHALL carry ID_INIT.
REQ-026 I_id_clear SHALL take effect at the next slice start, and SHALL NOT alter the ID of a slice in progress.
REQ-027 O_slice_cnt SHALL increment by 1 at each slice start and SHALL saturate at 16'hFFFF.
REQ-028 I_cnt_clear SHALL zero O_slice_cnt; when I_cnt_clear coincides with a slice start, the clear SHALL win and the result SHALL be 0.
REQ-029 If a slice-length end and I_pla_eop coincide, there SHALL be a single slice end with no empty slice.

Reset
REQ-030 On I_pla_rst:
- FSM goes to IDLE.
- O_pla_data_rdy=0 while reset is asserted, and 1 on the first cycle after release.
- O_pla_slice_en=0, O_pla_slice_payload=0, O_pla_slice_id=0.
- O_slice_cnt=0.
- Next ID=ID_INIT.
REQ-031 A reset mid-slice SHALL abandon the slice, and the first post-reset slice SHALL carry ID_INIT.

Configuration
REQ-032 When PLA_SLICE_55D5_HDR_EN is defined, each slice SHALL begin with one inserted header word {16'h55D5, 1'b0, slice_id}, and O_pla_data_rdy SHALL be 0 during that header cycle.
- The header SHALL NOT count toward I_slice_len.
- The header SHALL NOT consume an ingress word.
REQ-033 When PLA_SLICE_55D5_HDR_EN is undefined, no header SHALL be inserted and slices SHALL contain payload words only.

Structure
REQ-034 A shared package SHALL hold:
- the FSM state encoding;
- the constant 16'h55D5;
- the ID width (15);
- the counter width (16).
REQ-035 A single sub-module, pla_sat_cnt16 (saturating counter with clear), SHALL be instantiated for O_slice_cnt; all other logic SHALL be flat.

Verification
REQ-036 Continuous vld, I_slice_len=4, 12 words, macro off -> 3 slices with IDs 0,1,2, 4 en cycles each, 1 low cycle between slices, O_slice_cnt=3.
REQ-037 ID_INIT=15'h7FFE, 3 slices -> IDs 7FFE, 7FFF, 0000.
REQ-038 I_slice_len=8, I_pla_eop on the 3rd word -> slice of 3 words, and the next slice starts with ID+1.
REQ-039 Macro on, I_slice_len=2 -> every slice is 3 en cycles: header 55D5_xxxx then 2 payload words; rdy=0 in the header cycle.
REQ-040 Reset asserted mid-slice after 2 words -> en=0 immediately, and the next slice ID equals ID_INIT.
REQ-041 I_cnt_clear in the same cycle as a slice start when O_slice_cnt=5 -> O_slice_cnt=0.

Source files
------------

// File: rtl/pla_slice_id_gen_pkg.sv
// pla_slice_id_gen_pkg
// Shared types and constants for the PLA slice/ID generator:
//   - FSM state encoding (IDLE / SLICE / GAP)
//   - slice header magic 16'h55D5
//   - ID width (15) and statistics counter width (16)
//   - eff_len(): maps a programmed slice length of 0 onto 1
package pla_slice_id_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLICE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'h55D5;
    localparam int          ID_W      = 15;
    localparam int          CNT_W     = 16;
    localparam int          DATA_W    = 32;
    localparam int          LEN_W     = 8;
    localparam int          GAP_W     = 4;

    // A length of zero would never terminate a slice, so it behaves as 1.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/pla_sat_cnt16.sv
// pla_sat_cnt16
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count sticks at all-ones.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (count -> 0)
//   clr  - synchronous clear, wins over inc
//   inc  - count up by one
//   cnt  - current count
module pla_sat_cnt16
    import pla_slice_id_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pla_slice_id_gen.sv
// pla_slice_id_gen
// Cuts an ingress word stream into slices of I_slice_len words (or shorter
// when I_pla_eop arrives), tags each slice with an incrementing 15-bit ID and
// forces GAP_CYCLES idle cycles between slices so that every slice begins on
// a rising edge of O_pla_slice_en. All outputs are registered.
//
// Optional feature: define PLA_SLICE_55D5_HDR_EN to prepend one header word
// {16'h55D5, 1'b0, slice_id} to every slice. The header does not consume an
// ingress word and does not count toward the slice length.
//
// Ports:
//   I_pla_312m5_clk      - clock
//   I_pla_rst            - asynchronous active-high reset
//   I_pla_data/_vld/eop  - ingress word, valid, last word of packet
//   O_pla_data_rdy       - ingress word accepted this cycle when vld=1
//   I_slice_len          - payload words per slice, sampled at slice start
//   I_id_clear           - next slice starts again at ID_INIT
//   I_cnt_clear          - zero the slice statistics counter
//   O_pla_slice_id       - ID of the slice currently on the output
//   O_pla_slice_payload  - slice word
//   O_pla_slice_en       - slice word valid
//   O_slice_cnt          - slices emitted, saturating
module pla_slice_id_gen
    import pla_slice_id_gen_pkg::*;
#(
    parameter int              GAP_CYCLES = 1,
    parameter logic [ID_W-1:0] ID_INIT    = 15'h0000
) (
    input  logic              I_pla_312m5_clk,
    input  logic              I_pla_rst,
    input  logic [DATA_W-1:0] I_pla_data,
    input  logic              I_pla_data_vld,
    input  logic              I_pla_eop,
    output logic              O_pla_data_rdy,
    input  logic [LEN_W-1:0]  I_slice_len,
    input  logic              I_id_clear,
    input  logic              I_cnt_clear,
    output logic [ID_W-1:0]   O_pla_slice_id,
    output logic [DATA_W-1:0] O_pla_slice_payload,
    output logic              O_pla_slice_en,
    output logic [CNT_W-1:0]  O_slice_cnt
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t             state_reg, state_next;
    logic               rdy_reg, rdy_next;
    logic               hdr_reg, hdr_next;    // header word is on the output
    logic               en_reg, en_next;
    logic [DATA_W-1:0]  payload_reg, payload_next;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    next_id_reg;          // ID the next slice will carry
    logic [LEN_W-1:0]   len_reg;              // effective length of this slice
    logic [LEN_W-1:0]   xfer_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
`ifdef PLA_SLICE_55D5_HDR_EN
    // First payload word is parked here while the header goes out.
    logic [DATA_W-1:0]  hold_reg, hold_next;
`endif

    logic               xfer;
    logic               slice_start;
    logic               slice_end;
    logic               gap_done;
    logic [ID_W-1:0]    id_use;
    logic [LEN_W-1:0]   xfer_cnt_inc;

    assign xfer         = I_pla_data_vld & rdy_reg;
    assign slice_start  = xfer & (state_reg == ST_IDLE);
    assign xfer_cnt_inc = xfer_cnt_reg + LEN_W'(1);
    // A clear coinciding with a slice start applies to that slice.
    assign id_use       = I_id_clear ? ID_INIT : next_id_reg;

    // Length end and eop share one term, so their coincidence ends the
    // slice exactly once.
    assign slice_end = xfer & (I_pla_eop |
                               (slice_start ? (eff_len(I_slice_len) == LEN_W'(1))
                                            : (xfer_cnt_inc == len_reg)));

    // The gap count is held while a late header's parked word drains.
    assign gap_done  = (state_reg == ST_GAP) & ~hdr_reg & (gap_cnt_reg == GAP_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (slice_start) state_next = slice_end ? ST_GAP : ST_SLICE;
            ST_SLICE: if (slice_end)   state_next = ST_GAP;
            ST_GAP:   if (gap_done)    state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        en_next      = xfer;
        payload_next = xfer ? I_pla_data : payload_reg;
`ifdef PLA_SLICE_55D5_HDR_EN
        hdr_next     = slice_start;
        hold_next    = hold_reg;
        if (slice_start) begin
            payload_next = {HDR_MAGIC, 1'b0, id_use};
            hold_next    = I_pla_data;
        end else if (hdr_reg) begin
            en_next      = 1'b1;
            payload_next = hold_reg;
        end
`else
        hdr_next     = 1'b0;
`endif
        rdy_next = ~hdr_next & (state_next != ST_GAP);
    end

    always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
        if (I_pla_rst) begin
            state_reg    <= ST_IDLE;
            rdy_reg      <= 1'b0;
            hdr_reg      <= 1'b0;
            en_reg       <= 1'b0;
            payload_reg  <= '0;
            id_reg       <= '0;
            next_id_reg  <= ID_INIT;
            len_reg      <= '0;
            xfer_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
`ifdef PLA_SLICE_55D5_HDR_EN
            hold_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            rdy_reg      <= rdy_next;
            hdr_reg      <= hdr_next;
            en_reg       <= en_next;
            payload_reg  <= payload_next;
`ifdef PLA_SLICE_55D5_HDR_EN
            hold_reg     <= hold_next;
`endif
            if (slice_start) begin
                len_reg      <= eff_len(I_slice_len);
                xfer_cnt_reg <= LEN_W'(1);
                id_reg       <= id_use;
                next_id_reg  <= id_use + ID_W'(1);
            end else begin
                if (xfer) begin
                    xfer_cnt_reg <= xfer_cnt_inc;
                end
                if (I_id_clear) begin
                    next_id_reg <= ID_INIT;
                end
            end
            if (state_reg != ST_GAP) begin
                gap_cnt_reg <= '0;
            end else if (!hdr_reg) begin
                gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
        end
    end

    pla_sat_cnt16 u_slice_cnt (
        .clk (I_pla_312m5_clk),
        .rst (I_pla_rst),
        .clr (I_cnt_clear),
        .inc (slice_start),
        .cnt (O_slice_cnt)
    );

    assign O_pla_data_rdy      = rdy_reg;
    assign O_pla_slice_en      = en_reg;
    assign O_pla_slice_payload = payload_reg;
    assign O_pla_slice_id      = id_reg;

endmodule

// File: tb/tb_pla_slice_id_gen.sv
// tb_pla_slice_id_gen
// Directed bench for pla_slice_id_gen. Two instances share one stimulus:
// dut_a uses ID_INIT=0, dut_b uses ID_INIT=15'h7FFE to exercise ID wrap.
// A negedge monitor records, per slice (rising edge of en): ID, length in en
// cycles, en-low cycles before it, first word and rdy in that first cycle.
module tb_pla_slice_id_gen;

`ifdef PLA_SLICE_55D5_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data;
    logic        vld;
    logic        eop;
    logic [7:0]  len;
    logic        id_clr;
    logic        cnt_clr;

    logic        a_rdy, a_en, b_rdy, b_en;
    logic [14:0] a_id, b_id;
    logic [31:0] a_pl, b_pl;
    logic [15:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    pla_slice_id_gen dut_a (
        .I_pla_312m5_clk     (clk),
        .I_pla_rst           (rst),
        .I_pla_data          (data),
        .I_pla_data_vld      (vld),
        .I_pla_eop           (eop),
        .O_pla_data_rdy      (a_rdy),
        .I_slice_len         (len),
        .I_id_clear          (id_clr),
        .I_cnt_clear         (cnt_clr),
        .O_pla_slice_id      (a_id),
        .O_pla_slice_payload (a_pl),
        .O_pla_slice_en      (a_en),
        .O_slice_cnt         (a_cnt)
    );

    pla_slice_id_gen #(.GAP_CYCLES(1), .ID_INIT(15'h7FFE)) dut_b (
        .I_pla_312m5_clk     (clk),
        .I_pla_rst           (rst),
        .I_pla_data          (data),
        .I_pla_data_vld      (vld),
        .I_pla_eop           (eop),
        .O_pla_data_rdy      (b_rdy),
        .I_slice_len         (len),
        .I_id_clear          (id_clr),
        .I_cnt_clear         (cnt_clr),
        .O_pla_slice_id      (b_id),
        .O_pla_slice_payload (b_pl),
        .O_pla_slice_en      (b_en),
        .O_slice_cnt         (b_cnt)
    );

    // ---------------- slice monitor ----------------
    logic [14:0] mon_id    [0:63];
    int          mon_len   [0:63];
    int          mon_gap   [0:63];
    logic [31:0] mon_first [0:63];
    logic        mon_rdy   [0:63];
    logic [14:0] mon_bid   [0:63];
    int          n_a = 0;
    int          n_b = 0;
    int          a_low = 99;
    logic        a_prev = 1'b0;
    logic        b_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            a_prev = 1'b0;
            b_prev = 1'b0;
            a_low  = 99;
        end else begin
            if (a_en && !a_prev && n_a < 64) begin
                mon_id[n_a]    = a_id;
                mon_len[n_a]   = 1;
                mon_gap[n_a]   = a_low;
                mon_first[n_a] = a_pl;
                mon_rdy[n_a]   = a_rdy;
                n_a++;
            end else if (a_en && a_prev && n_a > 0) begin
                mon_len[n_a-1]++;
            end
            if (b_en && !b_prev && n_b < 64) begin
                mon_bid[n_b] = b_id;
                n_b++;
            end
            a_low  = a_en ? 0 : a_low + 1;
            a_prev = a_en;
            b_prev = b_en;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok %s: %h", tag, got);
        end
    endtask

    // Drive n consecutive words, vld held high; waits on rdy for each word.
    // Leaves vld high afterwards so the caller decides when it drops.
    task automatic send_burst(input int n, input logic [31:0] d0, input logic [31:0] eop_mask);
        for (int i = 0; i < n; i++) begin
            int w;
            @(negedge clk);
            vld  = 1'b1;
            data = d0 + 32'(i);
            eop  = eop_mask[i];
            w = 0;
            while (!a_rdy && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("rdy_wait_%h", data), 32'(a_rdy), 32'd1);
            @(posedge clk);
        end
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        vld = 1'b0;
        eop = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after 200000 time units");
        $fatal(1);
    end

    initial begin
        int ab, bb;
        logic [14:0] e15;
        vld = 1'b0; data = '0; eop = 1'b0; len = 8'd4; id_clr = 1'b0; cnt_clr = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rdy", 32'(a_rdy), 32'd0);
        chk("rst_en",  32'(a_en),  32'd0);
        chk("rst_pl",  a_pl,       32'd0);
        chk("rst_id",  32'(a_id),  32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy", 32'(a_rdy), 32'd1);

        // T1: len 4, 12 continuous words -> 3 slices
        ab = n_a; bb = n_b; len = 8'd4;
        send_burst(12, 32'h100, 32'h0);
        go_idle(6);
        chk("t1_nsl", 32'(n_a - ab), 32'd3);
        for (int i = 0; i < 3; i++) begin
            e15 = 15'h7FFE + 15'(i);
            chk($sformatf("t1_id%0d", i),  32'(mon_id[ab+i]),  32'(i));
            chk($sformatf("t1_len%0d", i), 32'(mon_len[ab+i]), 32'(4 + HDR));
            chk($sformatf("t1_bid%0d", i), 32'(mon_bid[bb+i]), 32'(e15));
        end
        chk("t1_gap1", 32'(mon_gap[ab+1]), 32'd1);
        chk("t1_gap2", 32'(mon_gap[ab+2]), 32'd1);
        chk("t1_first1", mon_first[ab+1], (HDR == 1) ? 32'h55D5_0001 : 32'h0000_0104);
`ifdef PLA_SLICE_55D5_HDR_EN
        chk("t1_hdr_rdy", 32'(mon_rdy[ab]), 32'd0);
`endif
        chk("t1_cnt", 32'(a_cnt), 32'd3);

        // T2: len 8, eop on word 3 and 5 -> slices of 3 and 2
        ab = n_a; bb = n_b; len = 8'd8;
        send_burst(5, 32'h200, 32'b10100);
        go_idle(6);
        chk("t2_nsl",  32'(n_a - ab),        32'd2);
        chk("t2_len0", 32'(mon_len[ab]),     32'(3 + HDR));
        chk("t2_len1", 32'(mon_len[ab+1]),   32'(2 + HDR));
        chk("t2_id0",  32'(mon_id[ab]),      32'd3);
        chk("t2_id1",  32'(mon_id[ab+1]),    32'd4);
        chk("t2_bid1", 32'(mon_bid[bb+1]),   32'h0002);
        chk("t2_cnt",  32'(a_cnt),           32'd5);

        // T3: cnt clear coincident with a slice start at cnt=5
        ab = n_a; bb = n_b;
        vld = 1'b1; data = 32'hC0DE; eop = 1'b1; cnt_clr = 1'b1;
        chk("t3_rdy", 32'(a_rdy), 32'd1);
        @(negedge clk);
        vld = 1'b0; eop = 1'b0; cnt_clr = 1'b0;
        chk("t3_cnt",    32'(a_cnt), 32'd0);
        chk("t3_gaprdy", 32'(a_rdy), 32'd0);
        go_idle(4);
        chk("t3_id",   32'(mon_id[ab]),  32'd5);
        chk("t3_bid",  32'(mon_bid[bb]), 32'd3);
        chk("t3_cnt2", 32'(a_cnt),       32'd0);

        // T4: id clear while idle, len 0 treated as 1
        @(negedge clk); id_clr = 1'b1;
        @(negedge clk); id_clr = 1'b0;
        ab = n_a; bb = n_b; len = 8'd0;
        send_burst(2, 32'h300, 32'h0);
        go_idle(6);
        chk("t4_nsl",  32'(n_a - ab),      32'd2);
        chk("t4_id0",  32'(mon_id[ab]),    32'd0);
        chk("t4_id1",  32'(mon_id[ab+1]),  32'd1);
        chk("t4_len0", 32'(mon_len[ab]),   32'(1 + HDR));
        chk("t4_bid0", 32'(mon_bid[bb]),   32'h7FFE);
        chk("t4_bid1", 32'(mon_bid[bb+1]), 32'h7FFF);
        chk("t4_first0", mon_first[ab], (HDR == 1) ? 32'h55D5_0000 : 32'h0000_0300);
        chk("t4_cnt",  32'(a_cnt),         32'd2);

        // T5: reset in the middle of a slice after 2 words
        len = 8'd8;
        send_burst(2, 32'h400, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_en",  32'(a_en),  32'd0);
        chk("t5_rdy", 32'(a_rdy), 32'd0);
        chk("t5_id",  32'(a_id),  32'd0);
        chk("t5_cnt", 32'(a_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        @(negedge clk);
        chk("t5_rel_rdy", 32'(a_rdy), 32'd1);
        ab = n_a; bb = n_b;
        send_burst(1, 32'h500, 32'h1);
        go_idle(4);
        chk("t5_nsl",  32'(n_a - ab),     32'd1);
        chk("t5_id0",  32'(mon_id[ab]),   32'd0);
        chk("t5_bid0", 32'(mon_bid[bb]),  32'h7FFE);
        chk("t5_cnt1", 32'(a_cnt),        32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
